adc_sample_buffer: RTL and testbench
====================================

# adc_sample_buffer

Captures one parallel multi-channel ADC sample per `adc_strobe`, applies optional decimation, and buffers accepted samples in a small first-word-fall-through FIFO. It sits directly upstream of the AXI-Stream serializer, whose `in_ready/in_valid/in_data` handshake it drives. The ADC front end cannot be stalled, so backpressure is absorbed here. Dropped samples are counted and reported instead of stalling.

## Interface

- `SAMPLE_WIDTH`, 32: bits per channel sample; equals the serializer's stream width.
- `NO_CHANNELS`, 4: channels per sample.
- `FIFO_DEPTH`, 4: buffered samples; power of two, ≥2.
- `DECIM_WIDTH`, 16: width of the decimation factor.

Ports:

- `clk`  in  1  single clock for all logic.
- `resetn`  in  1  synchronous, active-low reset.
- `enable`  in  1  accept strobes when 1.
- `adc_strobe`  in  1  one-cycle pulse; `adc_data` is valid in that cycle.
- `adc_data`  in  SAMPLE_WIDTH*NO_CHANNELS  channel k is at `[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]`.
- `decim`  in  DECIM_WIDTH  keep one sample out of every `decim+1` strobes.
- `out_ready`  in  1  downstream ready (serializer `in_ready`).
- `out_valid`  out  1  FIFO not empty.
- `out_data`  out  SAMPLE_WIDTH*NO_CHANNELS  head of the FIFO, channel layout unchanged.
- `level`  out  clogb2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
- `overflow`  out  1  sticky drop flag.
- `overflow_count`  out  32  dropped-sample count, saturating.
- `clear_overflow`  in  1  clears `overflow` and `overflow_count`.

## Operation

- **Reset** (`resetn`=0 at a clock edge):
  - FIFO read/write pointers, `level`, decimation counter, `overflow` and `overflow_count` go to 0.
  - FIFO storage is cleared, so `out_data`=0 and `out_valid`=0.
- **Decimation counter `dcnt`:**
  - While `enable`=0, `dcnt` is held at 0 and strobes are ignored. They are neither accepted nor counted as drops.
  - A strobe with `enable`=1 and `dcnt`=0 is accepted, and `dcnt` is loaded with `decim` (sampled at that edge).
  - A strobe with `enable`=1 and `dcnt`≠0 decrements `dcnt`; the sample is discarded and is not a drop.
  - A `decim` change takes effect at the next accepted sample.
- **Push:** an accepted sample is written at `wr_ptr` if `level`<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped: `overflow`←1 and `overflow_count` increments, saturating at 0xFFFF_FFFF.
- **Pop:** occurs when `out_valid`=1 and `out_ready`=1; `rd_ptr` advances.
- **Level update:**
  - Push only: `level`+1.
  - Pop only: `level`−1.
  - Push and pop together: unchanged.
- **Pointer wrap:** pointers wrap modulo FIFO_DEPTH. Full and empty are decided from `level`, not from pointer equality.
- **`clear_overflow`:**
  - Clears `overflow` and `overflow_count`.
  - If a drop occurs in the same cycle, the result is `overflow`=1 and `overflow_count`=1.
- **Deasserting `enable` mid-stream:** no new pushes; buffered samples keep draining normally.
- **Data path:** no arithmetic on `adc_data`; words are stored and forwarded bit-exact. Channel 0 (the LSB word) is the serializer's first output.

## Timing

- **Latency:** a strobe accepted at edge N into an empty FIFO gives `out_valid`=1 with that data after edge N (visible in cycle N+1).
- **FWFT:** `out_data` always equals the FIFO head. After a pop at edge N, the next head is presented in cycle N+1.
- **Throughput:** one push and one pop per cycle.
- **Handshake rules:**
  - `out_valid` never drops without a pop or reset.
  - `out_data` is stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` does not depend combinationally on `out_ready`.
- **Outputs:** `level`, `overflow` and `overflow_count` are registered and update at the same edge as the push, pop or drop that changes them.
- **Reset priority:** reset mid-operation discards all buffered samples. Reset has priority over every other input in that cycle.

## Structure

- `clogb2` and the channel-slice convention (`k*SAMPLE_WIDTH +: SAMPLE_WIDTH`) belong in the shared include `axis_util.vh`, which the serializer also uses.
- One sub-module: `sync_fifo_fwft` (parameters WIDTH and DEPTH). It provides storage, pointers, `level`, push/pop and simultaneous-full push/pop.
- The top level holds the decimation counter and the overflow logic.

## Test plan

All scenarios use the default parameters.

1. **Reset, then basic capture:** reset, then `enable`=1, `decim`=0, `out_ready`=1, one strobe with data {0x4,0x3,0x2,0x1} → `out_valid`=1 for exactly one cycle, one cycle after the strobe, with `out_data`=0x00000004_00000003_00000002_00000001; `level` goes 0→1→0.
2. **Decimation:** `decim`=2, 9 strobes with channel-0 values 1..9 → only samples 1, 4 and 7 appear, in order.
3. **Overflow and saturation setup:** `out_ready`=0, `decim`=0, 6 strobes → `level`=4, `overflow`=1, `overflow_count`=2. Then raise `out_ready` → the first 4 samples drain in order. The count is held until `clear_overflow`, which sets it to 0.
4. **Full with simultaneous push/pop:** FIFO full, `out_ready`=1, strobe in the same cycle → no drop, `level` stays 4, order is preserved.
5. **Enable and clear interactions:**
   - `enable`=0 while strobing → `level` and `overflow_count` unchanged.
   - `clear_overflow` coinciding with a drop → `overflow_count`=1.
6. **Reset mid-stream:** assert `resetn`=0 with `level`=3 → next cycle `out_valid`=0, `level`=0, `out_data`=0, counters 0.

Source files
------------

// File: rtl/adc_sample_buffer_pkg.sv
// Shared helpers for the ADC sample buffer: sizing function and counter limits.
package adc_sample_buffer_pkg;

  localparam int unsigned OVF_COUNT_W = 32;
  localparam logic [OVF_COUNT_W-1:0] OVF_COUNT_MAX = '1;

  // Ceiling log2; used for pointer and occupancy widths.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_sample_buffer_fifo.sv
// First-word-fall-through FIFO with occupancy-based full/empty and
// push-while-full allowed when a pop happens in the same cycle.
module sync_fifo_fwft
  import adc_sample_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    valid_o,
  output logic                    full_o,
  output logic [clogb2(DEPTH):0]  level_o
);

  localparam int unsigned AW = clogb2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Occupancy next state from push/pop combination.
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) level_d = level_q + LW'(1);
    else if (do_pop && !do_push) level_d = level_q - LW'(1);
  end

  // Storage, pointers and occupancy; reset clears storage so the head reads zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/adc_sample_buffer.sv
// ADC sample capture: decimation, FWFT buffering and drop accounting.
module adc_sample_buffer
  import adc_sample_buffer_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 32,
  parameter int unsigned NO_CHANNELS  = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DECIM_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                enable,
  input  logic                                adc_strobe,
  input  logic [SAMPLE_WIDTH*NO_CHANNELS-1:0] adc_data,
  input  logic [DECIM_WIDTH-1:0]              decim,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [SAMPLE_WIDTH*NO_CHANNELS-1:0] out_data,
  output logic [clogb2(FIFO_DEPTH):0]         level,
  output logic                                overflow,
  output logic [OVF_COUNT_W-1:0]              overflow_count,
  input  logic                                clear_overflow
);

  logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
  logic                   overflow_q, overflow_d;
  logic [OVF_COUNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic                   accept, fifo_full, drop;

  assign accept = enable & adc_strobe & (dcnt_q == '0);
  // A drop is an accepted sample that finds the FIFO full with no pop this cycle.
  assign drop   = accept & fifo_full & ~(out_valid & out_ready);

  sync_fifo_fwft #(
    .WIDTH (SAMPLE_WIDTH*NO_CHANNELS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (accept),
    .pop_i   (out_ready),
    .wdata_i (adc_data),
    .rdata_o (out_data),
    .valid_o (out_valid),
    .full_o  (fifo_full),
    .level_o (level)
  );

  // Decimation counter and overflow accounting next state.
  always_comb begin
    dcnt_d     = dcnt_q;
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (!enable) dcnt_d = '0;
    else if (adc_strobe) dcnt_d = (dcnt_q == '0) ? decim : dcnt_q - DECIM_WIDTH'(1);
    if (clear_overflow) begin
      overflow_d = drop;
      ovf_cnt_d  = drop ? OVF_COUNT_W'(1) : '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (ovf_cnt_q != OVF_COUNT_MAX) ovf_cnt_d = ovf_cnt_q + OVF_COUNT_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dcnt_q     <= '0;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      dcnt_q     <= dcnt_d;
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign overflow       = overflow_q;
  assign overflow_count = ovf_cnt_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Scoreboard bench for adc_sample_buffer: a behavioural model predicts
// accepted samples and counters; a negedge monitor compares DUT outputs.
module tb_adc_sample_buffer;

  localparam int unsigned SW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned DATA_W = SW*NC;

  logic              clk = 1'b0;
  logic              resetn, enable, adc_strobe, out_ready, clear_overflow;
  logic [DATA_W-1:0] adc_data;
  logic [DW-1:0]     decim;
  logic              out_valid, overflow;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        level;
  logic [31:0]       overflow_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state
  logic [DATA_W-1:0] exp_q[$];
  int unsigned       mdl_level = 0;
  int unsigned       mdl_skip = 0;
  bit                mdl_ovf = 0;
  longint unsigned   mdl_cnt = 0;
  bit                armed = 0;

  always #5 clk = ~clk;

  adc_sample_buffer #(
    .SAMPLE_WIDTH (SW),
    .NO_CHANNELS  (NC),
    .FIFO_DEPTH   (DEPTH),
    .DECIM_WIDTH  (DW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .adc_strobe     (adc_strobe),
    .adc_data       (adc_data),
    .decim          (decim),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .level          (level),
    .overflow       (overflow),
    .overflow_count (overflow_count),
    .clear_overflow (clear_overflow)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: a sample is kept when the number of strobes still to skip
  // is zero; it is queued when there is room or a pop frees a slot.
  always @(posedge clk) begin
    bit pop, acc, push, drop;
    if (!resetn) begin
      exp_q.delete();
      mdl_level = 0; mdl_skip = 0; mdl_ovf = 0; mdl_cnt = 0;
      armed = 1;
    end else begin
      pop = (mdl_level > 0) && out_ready;
      acc = 0;
      if (!enable) mdl_skip = 0;
      else if (adc_strobe) begin
        if (mdl_skip == 0) begin acc = 1; mdl_skip = int'(decim); end
        else mdl_skip = mdl_skip - 1;
      end
      push = acc && (mdl_level < DEPTH || pop);
      drop = acc && !push;
      if (push) exp_q.push_back(adc_data);
      mdl_level = mdl_level + int'(push) - int'(pop);
      if (clear_overflow) begin
        mdl_ovf = drop; mdl_cnt = drop ? 1 : 0;
      end else if (drop) begin
        mdl_ovf = 1;
        if (mdl_cnt != 64'hFFFF_FFFF) mdl_cnt = mdl_cnt + 1;
      end
    end
  end

  // Monitor: compares outputs every cycle and retires the head on a handshake.
  always @(negedge clk) begin
    if (armed) begin
      check("out_valid", DATA_W'(out_valid), DATA_W'(mdl_level != 0));
      check("level", DATA_W'(level), DATA_W'(mdl_level));
      check("overflow", DATA_W'(overflow), DATA_W'(mdl_ovf));
      check("overflow_count", DATA_W'(overflow_count), DATA_W'(mdl_cnt));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL out_data: got %h with no expected sample", out_data);
        end else begin
          check("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DATA_W-1:0] d);
    adc_strobe = 1'b1; adc_data = d;
    tick();
    adc_strobe = 1'b0; adc_data = '0;
  endtask

  function automatic logic [DATA_W-1:0] ch0(input int unsigned v);
    return DATA_W'(v);
  endfunction

  initial begin
    resetn = 1'b0; enable = 1'b0; adc_strobe = 1'b0; adc_data = '0;
    decim = '0; out_ready = 1'b0; clear_overflow = 1'b0;
    tick(); tick();
    check("reset out_data", out_data, '0);
    check("reset level", DATA_W'(level), '0);
    resetn = 1'b1;

    // 1: basic capture
    enable = 1'b1; decim = '0; out_ready = 1'b1;
    strobe({32'h4, 32'h3, 32'h2, 32'h1});
    check("capture data", out_data, {32'h4, 32'h3, 32'h2, 32'h1});
    check("capture level", DATA_W'(level), DATA_W'(1));
    tick(); tick();

    // 2: decimation, keep 1 of 3
    decim = DW'(2);
    for (int unsigned i = 1; i <= 9; i++) strobe(ch0(i));
    decim = '0;
    tick(); tick(); tick();

    // 3: overflow with stalled output
    out_ready = 1'b0;
    for (int unsigned i = 11; i <= 16; i++) strobe(ch0(i));
    check("ovf level", DATA_W'(level), DATA_W'(4));
    check("ovf count", DATA_W'(overflow_count), DATA_W'(2));
    out_ready = 1'b1;
    repeat (6) tick();
    check("ovf count held", DATA_W'(overflow_count), DATA_W'(2));
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    check("ovf count cleared", DATA_W'(overflow_count), '0);

    // 4: full with simultaneous push and pop
    out_ready = 1'b0;
    for (int unsigned i = 21; i <= 24; i++) strobe(ch0(i));
    out_ready = 1'b1;
    strobe(ch0(25));
    check("full pushpop level", DATA_W'(level), DATA_W'(4));
    check("full pushpop no drop", DATA_W'(overflow_count), '0);
    repeat (6) tick();

    // 5: enable low ignores strobes; clear coinciding with a drop
    enable = 1'b0;
    for (int unsigned i = 0; i < 3; i++) strobe(ch0(30 + i));
    check("disabled level", DATA_W'(level), '0);
    enable = 1'b1; out_ready = 1'b0;
    for (int unsigned i = 0; i < 6; i++) strobe(ch0(40 + i));
    clear_overflow = 1'b1; strobe(ch0(50)); clear_overflow = 1'b0;
    check("clear with drop", DATA_W'(overflow_count), DATA_W'(1));
    out_ready = 1'b1; repeat (6) tick();

    // 6: reset mid-stream with three buffered
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) strobe(ch0(60 + i));
    check("pre-reset level", DATA_W'(level), DATA_W'(3));
    resetn = 1'b0; strobe(ch0(70)); resetn = 1'b1;
    check("mid reset out_data", out_data, '0);
    check("mid reset valid", DATA_W'(out_valid), '0);

    // Randomized traffic
    for (int unsigned c = 0; c < 400; c++) begin
      enable         = ($urandom_range(0, 9) != 0);
      adc_strobe     = $urandom_range(0, 1) == 1;
      adc_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
      decim          = DW'($urandom_range(0, 2));
      out_ready      = ($urandom_range(0, 9) < 6);
      clear_overflow = ($urandom_range(0, 19) == 0);
      resetn         = ($urandom_range(0, 199) != 0);
      tick();
    end
    adc_strobe = 1'b0; resetn = 1'b1; out_ready = 1'b1; clear_overflow = 1'b0;
    repeat (8) tick();
    check("final empty", DATA_W'(level), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
